dual_port_ram_stream_reader: RTL and testbench

- Read-side engine for one port of dual_port_RAM (registered address, combinational data out).
- Accepts a (start address, length) command and streams that many consecutive RAM words onto a valid/ready master interface with full backpressure support.
- Absorbs the RAM's 2-cycle issue-to-data latency in a 4-entry output buffer; sustains 1 word/cycle when downstream is always ready.

---
 rtl/dual_port_ram_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_dual_port_ram_stream_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_stream_reader.sv
// Read-side streaming engine for one port of a dual-port RAM with a registered
// address and combinational data out. A (start address, length) command is
// turned into a run of consecutive RAM reads presented on a valid/ready stream.
// Two cycles of RAM latency are covered by a small credit-controlled buffer.
module dual_port_ram_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int RAM_DEPTH    = 256,
    parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH),
    parameter int LEN_WIDTH    = LB_RAM_DEPTH + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LB_RAM_DEPTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    abort,
    output logic [LB_RAM_DEPTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic                    ram_wr_en,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int BUF_DEPTH = 4;

    state_t                  state_q, state_d;
    logic [LB_RAM_DEPTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [LB_RAM_DEPTH-1:0] ram_addr_q, ram_addr_d;
    logic                    p1_valid_q, p1_valid_d;
    logic                    p1_last_q, p1_last_d;
    logic                    p2_valid_q, p2_valid_d;
    logic                    p2_last_q, p2_last_d;
    logic [DATA_WIDTH-1:0]   buf_data_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_data_d [BUF_DEPTH];
    logic                    buf_last_q [BUF_DEPTH];
    logic                    buf_last_d [BUF_DEPTH];
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              count_q, count_d;

    logic [2:0] credit_used;
    logic       can_issue;
    logic       issue_last;
    logic       buf_push;
    logic       buf_pop;
    logic       cmd_fire;

    assign m_valid     = (count_q != 3'd0);
    assign m_data      = m_valid ? buf_data_q[rd_ptr_q] : '0;
    assign m_last      = m_valid & buf_last_q[rd_ptr_q];
    assign busy        = (state_q != IDLE);
    assign cmd_ready   = (state_q == IDLE) && !abort;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = '0;
    assign ram_wr_en   = 1'b0;

    // Words buffered plus words still travelling through the RAM must never exceed
    // the buffer size, so a new read is only issued while a slot is guaranteed.
    assign credit_used = count_q + 3'(p1_valid_q) + 3'(p2_valid_q);
    assign can_issue   = (state_q == READ) && (remaining_q != '0) &&
                         (credit_used < 3'(BUF_DEPTH)) && !abort;
    assign issue_last  = (remaining_q == LEN_WIDTH'(1));
    assign buf_push    = p2_valid_q;
    assign buf_pop     = m_valid && m_ready;

    // Next-state logic: command intake, read issue, latency pipeline, buffer and abort flush.
    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        ram_addr_d  = ram_addr_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        p1_valid_d  = can_issue;
        p1_last_d   = can_issue && issue_last;
        p2_valid_d  = p1_valid_q;
        p2_last_d   = p1_last_q;

        if (buf_push) begin
            buf_data_d[wr_ptr_q] = ram_dout;
            buf_last_d[wr_ptr_q] = p2_last_q;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (buf_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({buf_push, buf_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    next_addr_d = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_len != '0) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (can_issue) begin
                    ram_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + LB_RAM_DEPTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (buf_pop && buf_last_q[rd_ptr_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            remaining_d = '0;
            p1_valid_d  = 1'b0;
            p1_last_d   = 1'b0;
            p2_valid_d  = 1'b0;
            p2_last_d   = 1'b0;
            wr_ptr_d    = 2'd0;
            rd_ptr_d    = 2'd0;
            count_d     = 3'd0;
        end
    end

    // State, pipeline and buffer registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            p2_valid_q  <= 1'b0;
            p2_last_q   <= 1'b0;
            buf_data_q  <= '{default: '0};
            buf_last_q  <= '{default: 1'b0};
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            ram_addr_q  <= ram_addr_d;
            p1_valid_q  <= p1_valid_d;
            p1_last_q   <= p1_last_d;
            p2_valid_q  <= p2_valid_d;
            p2_last_q   <= p2_last_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_stream_reader.sv
// Testbench for dual_port_ram_stream_reader: a behavioural RAM preloaded with
// ram[i]=i, a table of streaming commands, and hand-written sequences for
// backpressure, zero length, abort and mid-stream reset.
module tb_dual_port_ram_stream_reader;

    typedef struct {
        logic [7:0] addr;
        logic [8:0] len;
        logic [7:0] firstData;
        logic [7:0] lastData;
        int         firstCycle;
    } vecT;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [8:0] cmd_len;
    logic       abort;
    logic [7:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_wr_en;
    logic [7:0] ram_dout;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;

    logic [7:0] ramMem [256];
    logic [7:0] ramAddrReg;

    int compared   = 0;
    int mismatched = 0;

    vecT vectors [3];

    dual_port_ram_stream_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_wr_en (ram_wr_en),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached RAM read port: registered address, combinational data.
    initial ramAddrReg = 8'd0;
    always @(posedge clk) ramAddrReg <= ram_addr;
    assign ram_dout = ramMem[ramAddrReg];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one command at a falling edge and returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [7:0] addr, input logic [8:0] len);
        checkOutput("cmd_ready before command", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Collects stream beats; cycle 0 is the falling edge just after command acceptance.
    task automatic collectBeats(input logic [7:0] firstData, input int expCount, input int expLastAt,
                                input bit randomReady, input bit checkTiming, input int firstCycle,
                                output logic [7:0] lastData);
        int beats     = 0;
        int cycle     = 0;
        int firstSeen = -1;
        int budget    = expCount * 8 + 40;
        lastData = 8'h00;
        while (beats < expCount && cycle < budget) begin
            if (m_valid && firstSeen < 0) firstSeen = cycle;
            m_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                checkOutput("beat data", 32'(m_data), 32'(8'(firstData + 8'(beats))));
                checkOutput("beat last", 32'(m_last), 32'(beats == expLastAt));
                if (checkTiming) checkOutput("beat cycle", 32'(cycle), 32'(firstCycle + beats));
                lastData = m_data;
                beats++;
            end
            @(negedge clk);
            cycle++;
        end
        checkOutput("beat count", 32'(beats), 32'(expCount));
        if (checkTiming) checkOutput("first m_valid cycle", 32'(firstSeen), 32'(firstCycle));
    endtask

    // Checks the idle condition that must follow a completed or flushed command.
    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, " m_valid"}, 32'(m_valid), 32'd0);
        checkOutput({tag, " ram_wr_en"}, 32'(ram_wr_en), 32'd0);
        checkOutput({tag, " ram_din"}, 32'(ram_din), 32'd0);
    endtask

    task automatic runVector(input vecT v);
        logic [7:0] lastData;
        m_ready = 1'b1;
        applyStimulus(v.addr, v.len);
        collectBeats(v.firstData, int'(v.len), int'(v.len) - 1, 1'b0, 1'b1, v.firstCycle, lastData);
        checkOutput("final beat data", 32'(lastData), 32'(v.lastData));
        checkIdle("after command");
    endtask

    // Main stimulus sequence.
    initial begin
        logic [7:0] savedAddr;
        logic [7:0] prevAddr;
        logic [7:0] lastData;
        int         issues;
        int         unstable;

        for (int i = 0; i < 256; i++) ramMem[i] = 8'(i);

        vectors[0] = '{addr: 8'h10, len: 9'd4,   firstData: 8'h10, lastData: 8'h13, firstCycle: 3};
        vectors[1] = '{addr: 8'hFE, len: 9'd4,   firstData: 8'hFE, lastData: 8'h01, firstCycle: 3};
        vectors[2] = '{addr: 8'h80, len: 9'd256, firstData: 8'h80, lastData: 8'h7F, firstCycle: 3};

        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 9'd0;
        abort     = 1'b0;
        m_ready   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset m_data", 32'(m_data), 32'd0);
        checkOutput("reset m_last", 32'(m_last), 32'd0);
        checkIdle("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) runVector(vectors[i]);

        // Zero-length command: nothing happens and the engine stays ready.
        savedAddr = ram_addr;
        applyStimulus(8'h33, 9'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("len0 m_valid", 32'(m_valid), 32'd0);
            checkOutput("len0 m_last", 32'(m_last), 32'd0);
            checkOutput("len0 busy", 32'(busy), 32'd0);
            checkOutput("len0 cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("len0 ram_addr", 32'(ram_addr), 32'(savedAddr));
            @(negedge clk);
        end
        runVector('{addr: 8'h05, len: 9'd1, firstData: 8'h05, lastData: 8'h05, firstCycle: 3});

        // Backpressure: exactly four reads issued while m_ready is held low.
        m_ready  = 1'b0;
        issues   = 0;
        unstable = 0;
        prevAddr = ram_addr;
        applyStimulus(8'h00, 9'd10);
        for (int i = 0; i < 20; i++) begin
            if (ram_addr != prevAddr) issues++;
            prevAddr = ram_addr;
            if (i >= 3 && (m_valid !== 1'b1 || m_data !== 8'h00 || m_last !== 1'b0)) unstable++;
            @(negedge clk);
        end
        checkOutput("backpressure issue count", 32'(issues), 32'd4);
        checkOutput("backpressure last ram_addr", 32'(ram_addr), 32'd3);
        checkOutput("backpressure unstable cycles", 32'(unstable), 32'd0);
        checkOutput("backpressure m_valid", 32'(m_valid), 32'd1);
        checkOutput("backpressure m_data", 32'(m_data), 32'd0);
        collectBeats(8'h00, 10, 9, 1'b1, 1'b0, 0, lastData);
        checkOutput("backpressure final data", 32'(lastData), 32'h09);
        checkIdle("after backpressure");

        // Abort after the fifth beat of a sixteen-word command.
        m_ready = 1'b1;
        applyStimulus(8'h20, 9'd16);
        collectBeats(8'h20, 5, 15, 1'b0, 1'b1, 3, lastData);
        checkOutput("pre-abort m_valid", 32'(m_valid), 32'd1);
        checkOutput("pre-abort m_data", 32'(m_data), 32'h25);
        savedAddr = ram_addr;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort m_valid", 32'(m_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ram_addr hold", 32'(ram_addr), 32'(savedAddr));
        abort = 1'b0;
        #1;
        checkOutput("abort cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post-abort m_valid", 32'(m_valid), 32'd0);
        end
        runVector('{addr: 8'h40, len: 9'd2, firstData: 8'h40, lastData: 8'h41, firstCycle: 3});

        // A command offered together with abort must be refused.
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h60;
        cmd_len   = 9'd2;
        #1;
        checkOutput("abort blocks cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("abort blocks acceptance", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("refused cmd m_valid", 32'(m_valid), 32'd0);
        end

        // Reset while reading with data waiting in the buffer.
        m_ready = 1'b0;
        applyStimulus(8'h50, 9'd8);
        repeat (4) @(negedge clk);
        checkOutput("pre-reset m_valid", 32'(m_valid), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("mid reset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("mid reset m_data", 32'(m_data), 32'd0);
        checkOutput("mid reset m_last", 32'(m_last), 32'd0);
        checkIdle("mid reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        runVector('{addr: 8'h03, len: 9'd1, firstData: 8'h03, lastData: 8'h03, firstCycle: 3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
